hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit with load-use detection, multi-cycle MDU tracking and stall counting
// Ports:
//   clk, reset (async, active-low)
//   rsD, rtD, rs_readD, rt_readD   : source registers of the D-stage instruction and their read enables
//   loadE, ld_dstE                 : E-stage load flag and its destination register
//   md_useD                        : D-stage instruction uses the mult/div unit or HI/LO
//   md_startE, md_opE              : mult/div issue from E (md_opE 0 = mult, 1 = div)
//   exc_req                        : exception/interrupt commit
//   stallF, stallD, flushE         : pipeline control
//   md_busy, md_done, md_cnt       : MDU status
//   stall_cnt                      : saturating count of stalled cycles
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        rs_readD,
    input  logic        rt_readD,
    input  logic        loadE,
    input  logic [4:0]  ld_dstE,
    input  logic        md_useD,
    input  logic        md_startE,
    input  logic        md_opE,
    input  logic        exc_req,
    output logic        stallF,
    output logic        stallD,
    output logic        flushE,
    output logic        md_busy,
    output logic        md_done,
    output logic [3:0]  md_cnt,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

    state_t state;
    logic   start;
    logic   load_use;
    logic   md_haz;
    logic   stall;

    // an exception in the issue cycle cancels the start
    assign start    = md_startE & ~exc_req;
    assign md_busy  = (state != IDLE) | start;
    assign load_use = loadE & (ld_dstE != 5'd0) &
                      ((rs_readD & (rsD == ld_dstE)) | (rt_readD & (rtD == ld_dstE)));
    assign md_haz   = md_useD & md_busy;
    assign stall    = (load_use | md_haz) & ~exc_req;
    assign stallF   = stall;
    assign stallD   = stall;
    assign flushE   = stall | exc_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            md_cnt    <= 4'd0;
            md_done   <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            md_done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state  <= md_opE ? DIV : MULT;
                    md_cnt <= md_opE ? 4'd10 : 4'd5;
                end
            end else if (md_cnt == 4'd1) begin
                state   <= IDLE;
                md_cnt  <= 4'd0;
                md_done <= 1'b1;
            end else begin
                md_cnt <= md_cnt - 4'd1;
            end
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule
